// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target responder and the master controller:
// one-hot state encodings, default device type, R/W bit position, ACK levels
// and the word-address pointer increment helper.
package i2c_pkg;

   localparam int N_STATES = 10;

   typedef logic [N_STATES-1:0] state_t;

   // One-hot FSM encodings
   localparam logic [9:0] S_IDLE      = 10'b00_0000_0001;
   localparam logic [9:0] S_RX_CTRL   = 10'b00_0000_0010;
   localparam logic [9:0] S_ACK_CTRL  = 10'b00_0000_0100;
   localparam logic [9:0] S_RX_WADDR  = 10'b00_0000_1000;
   localparam logic [9:0] S_ACK_WADDR = 10'b00_0001_0000;
   localparam logic [9:0] S_RX_DATA   = 10'b00_0010_0000;
   localparam logic [9:0] S_ACK_DATA  = 10'b00_0100_0000;
   localparam logic [9:0] S_TX_DATA   = 10'b00_1000_0000;
   localparam logic [9:0] S_RX_MACK   = 10'b01_0000_0000;
   localparam logic [9:0] S_WAIT_STOP = 10'b10_0000_0000;

   // Upper four bits of the 7-bit address for 24Cxx-style EEPROMs
   localparam logic [3:0] DEV_TYPE_DEF = 4'b1010;

   // Position of the R/W flag inside the control byte (1 = read)
   localparam int RW_BIT = 0;

   // Line level during the acknowledge bit
   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   // Pointer increment; a one-byte pointer wraps inside the low page
   function automatic logic [15:0] addr_inc(input logic [15:0] a, input logic one_byte);
      logic [15:0] r;
      if (one_byte) r = {8'h00, a[7:0] + 8'd1};
      else          r = a + 16'd1;
      return r;
   endfunction

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Register-port bundle between the I2C target and a local register file/RAM.
// Strobe semantics: Reg_wr and Reg_rd are single-cycle strobes qualified by
// Reg_addr (and Reg_wdata for writes). There is no back-pressure: the register
// side accepts every strobe, and presents Reg_rdata exactly one Clk after the
// cycle in which Reg_rd is high.
interface i2c_slave_regs_if;
   logic [15:0] Reg_addr;
   logic [7:0]  Reg_wdata;
   logic        Reg_wr;
   logic        Reg_rd;
   logic [7:0]  Reg_rdata;

   modport master (output Reg_addr, output Reg_wdata, output Reg_wr,
                   output Reg_rd, input Reg_rdata);
   modport slave  (input Reg_addr, input Reg_wdata, input Reg_wr,
                   input Reg_rd, output Reg_rdata);
endinterface

// File: rtl/i2c_line_cond.sv
// I2C line conditioning: SYNC_STAGES-deep synchronizers on SCL/SDA, optional
// 4-sample stability filter (macro I2C_SLV_GLITCH_FILTER_EN), then SCL edge
// and START/STOP detection on the conditioned values.
module i2c_line_cond #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_in,
   input  logic sda_in,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic scl_f, sda_f;
   logic scl_q, sda_q;

   // Synchronizers; reset to the idle-high bus level so reset release makes no edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

`ifdef I2C_SLV_GLITCH_FILTER_EN
   logic [3:0] scl_hist, sda_hist;

   // Filtered level follows only after four consecutive equal samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_hist <= '1;
         sda_hist <= '1;
         scl_f    <= 1'b1;
         sda_f    <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[2:0], scl_sync[SYNC_STAGES-1]};
         sda_hist <= {sda_hist[2:0], sda_sync[SYNC_STAGES-1]};
         if (scl_hist == 4'hF) scl_f <= 1'b1;
         else if (scl_hist == 4'h0) scl_f <= 1'b0;
         if (sda_hist == 4'hF) sda_f <= 1'b1;
         else if (sda_hist == 4'h0) sda_f <= 1'b0;
      end
   end
`else
   assign scl_f = scl_sync[SYNC_STAGES-1];
   assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

   // Previous conditioned levels for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise  =  scl_f & ~scl_q;
   assign scl_fall  = ~scl_f &  scl_q;
   assign start_det =  scl_f &  scl_q &  sda_q & ~sda_f;
   assign stop_det  =  scl_f &  scl_q & ~sda_q &  sda_f;
   assign sda_s     =  sda_f;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target responder emulating a 24Cxx-style EEPROM: decodes the control
// word, takes a 1/2-byte word address with auto-increment and turns bus
// writes/reads into single-cycle register-port strobes. SCL is never stretched.
// Optional input glitch filter: define I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_regs
   import i2c_pkg::*;
#(
   parameter int         WADDR_BYTES = 2,
   parameter logic [3:0] DEV_TYPE    = DEV_TYPE_DEF,
   parameter int         SYNC_STAGES = 2
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic [2:0]       Device_addr,
   input  logic             Scl,
   inout  wire              Sda,
   i2c_slave_regs_if.master regs,
   output logic             Busy,
   output logic             Done,
   output logic [9:0]       dbg_state
);

   localparam logic [1:0] WA_LAST  = 2'(WADDR_BYTES);
   localparam logic       ONE_BYTE = (WADDR_BYTES == 1);

   state_t     state;
   logic       sda_oe;      // 1 = pull SDA low
   logic [3:0] bit_cnt;
   logic [6:0] rx_sh;
   logic [7:0] rx_byte;
   logic [7:0] tx_shift;
   logic       rw;
   logic       matched;
   logic       ack_phase;   // 0 = waiting for the fall after bit 8, 1 = ACK bit on the bus
   logic       mack_ack;
   logic [1:0] waddr_idx;
   logic       rd_req;
   logic       rd_cap;
   logic       scl_rise, scl_fall, start_det, stop_det, sda_s;

   i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES)) u_line (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .scl_in    (Scl),
      .sda_in    (Sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   // Open-drain output: only ever pulls low
   assign Sda       = sda_oe ? ACK : 1'bz;
   assign rx_byte   = {rx_sh, sda_s};
   assign dbg_state = state;

   // Protocol FSM, register-port strobes and pointer management
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= S_IDLE;
         sda_oe         <= 1'b0;
         bit_cnt        <= '0;
         rx_sh          <= '0;
         tx_shift       <= '0;
         rw             <= 1'b0;
         matched        <= 1'b0;
         ack_phase      <= 1'b0;
         mack_ack       <= 1'b0;
         waddr_idx      <= '0;
         rd_req         <= 1'b0;
         rd_cap         <= 1'b0;
         Busy           <= 1'b0;
         Done           <= 1'b0;
         regs.Reg_addr  <= '0;
         regs.Reg_wdata <= '0;
         regs.Reg_wr    <= 1'b0;
         regs.Reg_rd    <= 1'b0;
      end else begin
         regs.Reg_wr <= 1'b0;
         regs.Reg_rd <= rd_req;
         rd_req      <= 1'b0;
         rd_cap      <= regs.Reg_rd;
         Done        <= 1'b0;
         if (rd_cap) tx_shift <= regs.Reg_rdata;
         if (regs.Reg_wr) regs.Reg_addr <= addr_inc(regs.Reg_addr, ONE_BYTE);

         if (stop_det) begin
            state   <= S_IDLE;
            sda_oe  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= matched;
            matched <= 1'b0;
         end else if (start_det) begin
            // Also the repeated-START path; the pointer is deliberately kept
            state   <= S_RX_CTRL;
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            Busy    <= 1'b1;
            matched <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_WAIT_STOP: sda_oe <= 1'b0;

               S_RX_CTRL, S_RX_WADDR, S_RX_DATA: begin
                  if (scl_rise) begin
                     rx_sh   <= rx_byte[6:0];
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd7) begin
                        bit_cnt   <= '0;
                        ack_phase <= 1'b0;
                        if (state == S_RX_CTRL) begin
                           if (rx_byte[7:1] == {DEV_TYPE, Device_addr}) begin
                              matched <= 1'b1;
                              rw      <= rx_byte[RW_BIT];
                              state   <= S_ACK_CTRL;
                           end else begin
                              state <= S_WAIT_STOP;
                           end
                        end else if (state == S_RX_WADDR) begin
                           if (ONE_BYTE)                regs.Reg_addr       <= {8'h00, rx_byte};
                           else if (waddr_idx == 2'd0)  regs.Reg_addr[15:8] <= rx_byte;
                           else                         regs.Reg_addr[7:0]  <= rx_byte;
                           waddr_idx <= waddr_idx + 2'd1;
                           state     <= S_ACK_WADDR;
                        end else begin
                           regs.Reg_wdata <= rx_byte;
                           regs.Reg_wr    <= 1'b1;
                           state          <= S_ACK_DATA;
                        end
                     end
                  end
               end

               S_ACK_CTRL, S_ACK_WADDR, S_ACK_DATA: begin
                  if (scl_fall && !ack_phase) begin
                     sda_oe    <= 1'b1;
                     ack_phase <= 1'b1;
                  end else if (scl_rise && ack_phase && state == S_ACK_CTRL && rw) begin
                     regs.Reg_rd <= 1'b1;
                  end else if (scl_fall) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= '0;
                     if (state == S_ACK_CTRL && rw) begin
                        state    <= S_TX_DATA;
                        sda_oe   <= ~tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                     end else if (state == S_ACK_CTRL) begin
                        state     <= S_RX_WADDR;
                        waddr_idx <= '0;
                     end else if (state == S_ACK_WADDR && waddr_idx != WA_LAST) begin
                        state <= S_RX_WADDR;
                     end else begin
                        state <= S_RX_DATA;
                     end
                  end
               end

               S_TX_DATA: begin
                  if (scl_rise) begin
                     bit_cnt <= bit_cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe   <= 1'b0;
                        mack_ack <= 1'b0;
                        state    <= S_RX_MACK;
                     end else begin
                        sda_oe   <= ~tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                     end
                  end
               end

               S_RX_MACK: begin
                  if (scl_rise) begin
                     if (sda_s == NACK) begin
                        state <= S_WAIT_STOP;
                     end else begin
                        mack_ack      <= 1'b1;
                        regs.Reg_addr <= addr_inc(regs.Reg_addr, ONE_BYTE);
                        rd_req        <= 1'b1;
                     end
                  end else if (scl_fall && mack_ack) begin
                     state    <= S_TX_DATA;
                     bit_cnt  <= '0;
                     sda_oe   <= ~tx_shift[7];
                     tx_shift <= {tx_shift[6:0], 1'b0};
                  end
               end

               default: begin
                  state  <= S_IDLE;
                  sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, memory[n]=n
// register model, scoreboard queues for write and read strobes.
module tb_i2c_slave_regs;
   import i2c_pkg::*;

   localparam int Q = 6;  // quarter SCL period in Clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_sda_low = 1'b0;
   wire        sda;
   logic       busy, done;
   logic [9:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int busy_rises = 0;
   logic busy_prev = 1'b0;

   logic [23:0] wr_q[$];
   logic [15:0] rd_q[$];

   i2c_slave_regs_if bus ();

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave_regs dut (
      .Clk         (clk),
      .Rst_n       (rst_n),
      .Device_addr (3'b001),
      .Scl         (scl),
      .Sda         (sda),
      .regs        (bus),
      .Busy        (busy),
      .Done        (done),
      .dbg_state   (dbg_state)
   );

   // Clock / watchdog
   always #10 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "timeout");
   end

   // Register model: memory[n] = n, data one Clk after Reg_rd
   always @(posedge clk) begin
      if (bus.Reg_rd) bus.Reg_rdata <= bus.Reg_addr[7:0];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard / monitors
   always @(negedge clk) begin
      logic [31:0] e;
      if (bus.Reg_wr) begin
         e = (wr_q.size() != 0) ? {8'h00, wr_q.pop_front()} : 32'hFFFF_FFFF;
         check("reg_wr", {8'h00, bus.Reg_addr, bus.Reg_wdata}, e);
      end
      if (bus.Reg_rd) begin
         e = (rd_q.size() != 0) ? {16'h0000, rd_q.pop_front()} : 32'hFFFF_FFFF;
         check("reg_rd", {16'h0000, bus.Reg_addr}, e);
      end
      if (done) done_cnt++;
      if (busy && !busy_prev) busy_rises++;
      busy_prev <= busy;
   end

   // Driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      m_sda_low = 1'b0; tick(Q);
      scl = 1'b1;       tick(Q);
      m_sda_low = 1'b1; tick(Q);
      scl = 1'b0;       tick(Q);
   endtask

   task automatic i2c_stop();
      m_sda_low = 1'b1; tick(Q);
      scl = 1'b1;       tick(Q);
      m_sda_low = 1'b0; tick(Q);
      tick(4);
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b; tick(Q);
      scl = 1'b1;     tick(2 * Q);
      scl = 1'b0;     tick(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; tick(Q);
      scl = 1'b1;       tick(Q);
      b = sda;          tick(Q);
      scl = 1'b0;       tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic acked);
      logic b;
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(b);
      acked = (b == ACK);
   endtask

   task automatic read_byte(input logic send_ack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(send_ack ? ACK : NACK);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"},  bus.Reg_addr, 16'h0000);
      check({tag, "_wdata"}, bus.Reg_wdata, 8'h00);
      check({tag, "_wr"},    bus.Reg_wr, 1'b0);
      check({tag, "_rd"},    bus.Reg_rd, 1'b0);
      check({tag, "_busy"},  busy, 1'b0);
      check({tag, "_done"},  done, 1'b0);
      check({tag, "_sda"},   sda, 1'b1);
      check({tag, "_state"}, dbg_state, S_IDLE);
   endtask

   // Directed sequence
   initial begin
      logic       ack;
      logic [7:0] d;
      int         base, exp_rises;

      tick(3);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick(5);

      // 1) Two-byte write at 0x0010
      i2c_start();
      check("wr_busy", busy, 1'b1);
      write_byte(8'hA2, ack); check("wr_ack_ctrl", ack, 1'b1);
      write_byte(8'h00, ack); check("wr_ack_ah", ack, 1'b1);
      write_byte(8'h10, ack); check("wr_ack_al", ack, 1'b1);
      wr_q.push_back({16'h0010, 8'hA5});
      write_byte(8'hA5, ack); check("wr_ack_d0", ack, 1'b1);
      wr_q.push_back({16'h0011, 8'h5A});
      write_byte(8'h5A, ack); check("wr_ack_d1", ack, 1'b1);
      i2c_stop();
      check("wr_done", done_cnt, 1);
      check("wr_busy_end", busy, 1'b0);
      check("wr_addr_after", bus.Reg_addr, 16'h0012);

      // 2) Control word for another device: no ACK, no strobes, Busy held
      i2c_start();
      write_byte(8'hA4, ack); check("nm_ack_ctrl", ack, 1'b0);
      write_byte(8'h55, ack); check("nm_ack_data", ack, 1'b0);
      check("nm_busy", busy, 1'b1);
      check("nm_state", dbg_state, S_WAIT_STOP);
      i2c_stop();
      check("nm_done", done_cnt, 1);
      check("nm_busy_end", busy, 1'b0);

      // 3) Dummy write 0x0020, repeated START, 3-byte read
      i2c_start();
      write_byte(8'hA2, ack); check("rr_ack_ctrl", ack, 1'b1);
      write_byte(8'h00, ack); check("rr_ack_ah", ack, 1'b1);
      write_byte(8'h20, ack); check("rr_ack_al", ack, 1'b1);
      i2c_start();
      rd_q.push_back(16'h0020);
      write_byte(8'hA3, ack); check("rr_ack_rctrl", ack, 1'b1);
      rd_q.push_back(16'h0021);
      read_byte(1'b1, d); check("rr_data0", d, 8'h20);
      rd_q.push_back(16'h0022);
      read_byte(1'b1, d); check("rr_data1", d, 8'h21);
      read_byte(1'b0, d); check("rr_data2", d, 8'h22);
      tick(4);
      check("rr_sda_released", sda, 1'b1);
      check("rr_state", dbg_state, S_WAIT_STOP);
      check("rr_addr", bus.Reg_addr, 16'h0022);
      i2c_stop();
      check("rr_done", done_cnt, 2);

      // 4) Sequential write across the 0xFFFF wrap
      i2c_start();
      write_byte(8'hA2, ack); check("wp_ack_ctrl", ack, 1'b1);
      write_byte(8'hFF, ack); check("wp_ack_ah", ack, 1'b1);
      write_byte(8'hFF, ack); check("wp_ack_al", ack, 1'b1);
      wr_q.push_back({16'hFFFF, 8'h11});
      write_byte(8'h11, ack); check("wp_ack_d0", ack, 1'b1);
      wr_q.push_back({16'h0000, 8'h22});
      write_byte(8'h22, ack); check("wp_ack_d1", ack, 1'b1);
      i2c_stop();
      check("wp_addr", bus.Reg_addr, 16'h0001);
      check("wp_done", done_cnt, 3);

      // 5) Reset during bit 4 of a read byte (0x40: bit 4 on the bus is 0)
      i2c_start();
      write_byte(8'hA2, ack);
      write_byte(8'h00, ack);
      write_byte(8'h40, ack);
      i2c_start();
      rd_q.push_back(16'h0040);
      write_byte(8'hA3, ack); check("rs_ack_rctrl", ack, 1'b1);
      for (int i = 0; i < 3; i++) read_bit(d[i]);
      m_sda_low = 1'b0; tick(Q);
      scl = 1'b1;       tick(Q);
      check("rs_bit4_driven", sda, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rs_sda_async", sda, 1'b1);
      check_reset_outputs("rs");
      tick(3);
      rst_n = 1'b1;
      tick(5);
      i2c_start();
      write_byte(8'hA2, ack); check("rs2_ack_ctrl", ack, 1'b1);
      write_byte(8'h00, ack);
      write_byte(8'h50, ack);
      wr_q.push_back({16'h0050, 8'h77});
      write_byte(8'h77, ack); check("rs2_ack_d0", ack, 1'b1);
      i2c_stop();
      check("rs2_done", done_cnt, 4);

      // 6) Two-Clk low spike on SDA while SCL is high
      tick(10);
      base = busy_rises;
      m_sda_low = 1'b1; tick(2);
      m_sda_low = 1'b0; tick(20);
`ifdef I2C_SLV_GLITCH_FILTER_EN
      exp_rises = base;
`else
      exp_rises = base + 1;
`endif
      check("gl_start_seen", busy_rises, exp_rises);
      scl = 1'b0; tick(Q);
      i2c_stop();
      check("gl_state", dbg_state, S_IDLE);
      check("gl_busy", busy, 1'b0);
      check("gl_done", done_cnt, 4);

      tick(5);
      check("wr_q_empty", wr_q.size(), 0);
      check("rd_q_empty", rd_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
I2C target (slave) responder for the team's I2C bus: the far end of the I2C master controller.
- Decodes 7-bit control word {DEV_TYPE, Device_addr}.
- Accepts 1- or 2-byte word address with auto-increment.
- Turns bus writes and reads into single-cycle register-port strobes toward a local register file or RAM.
- Used to emulate 24Cxx-style EEPROM devices in SoC simulation and on FPGA.

Parameters:
WADDR_BYTES, 2, number of word-address bytes (1 or 2).
DEV_TYPE, 4'b1010, upper 4 bits of the 7-bit device address.
SYNC_STAGES, 2, synchronizer depth on Scl/Sda inputs (≥2).

Ports:
Clk  input  1  system clock, ≥16x SCL rate (50 MHz nominal).
Rst_n  input  1  asynchronous active-low reset.
Device_addr  input  3  lower 3 bits of the 7-bit device address (strap).
Scl  input  1  I2C clock (slave never stretches).
Sda  inout  1  I2C data; open-drain: driven 0 or released to z.
Reg_addr  output  16  current word-address pointer.
Reg_wdata  output  8  write data, valid while Reg_wr=1.
Reg_wr  output  1  1-cycle write strobe.
Reg_rd  output  1  1-cycle read strobe.
Reg_rdata  input  8  read data, valid exactly 1 Clk after Reg_rd.
Busy  output  1  high from START detect to STOP detect.
Done  output  1  1-cycle pulse on STOP following an addressed transaction.

Behaviour:
Reset values: Sda released (z), Reg_addr=0, Reg_wdata=0, Reg_wr=0, Reg_rd=0, Busy=0, Done=0, state IDLE.

Input conditioning:
- Scl/Sda pass through SYNC_STAGES flops; edge detect runs on synchronized values.
- START = Sda fall while Scl=1. STOP = Sda rise while Scl=1.
- Sampling: data sampled on the Scl rising-edge event.
- Driving: Sda changes only on the Scl falling-edge event, 1 Clk after it.

States:
- IDLE: Sda released. START goes to RX_CTRL.
- RX_CTRL: shift 8 bits MSB first.
  - Bits[7:1] ≠ {DEV_TYPE, Device_addr}: go to WAIT_STOP, no ACK driven.
  - R/W=0: go to ACK_CTRL, then RX_WADDR.
  - R/W=1: go to ACK_CTRL, then TX_DATA. Reg_rd is pulsed on the ACK-clock rising edge; Reg_rdata is captured 1 Clk later into the tx shift register.
- ACK_*: drive Sda=0 from the falling edge after bit 8 until the next falling edge.
- RX_WADDR: receive WADDR_BYTES bytes, ACK each.
  - 2 bytes: first byte → Reg_addr[15:8], second → Reg_addr[7:0].
  - 1 byte: Reg_addr = {8'h00, byte}.
  - Then RX_DATA.
- RX_DATA: after each 8th bit, Reg_wdata = byte and Reg_wr pulses 1 Clk; ACK; Reg_addr increments 1 Clk after Reg_wr.
- TX_DATA: drive tx bits MSB first (bit=0 → drive low, bit=1 → release). Then release Sda and go to RX_MACK.
- RX_MACK: sample Sda on the rising edge.
  - 0 (ACK): Reg_addr++, Reg_rd pulse 1 Clk later, reload, back to TX_DATA.
  - 1 (NACK): WAIT_STOP.
- WAIT_STOP: Sda released, waiting for STOP.

Pointer wrap: Reg_addr wraps 0xFFFF→0x0000. With WADDR_BYTES=1 it wraps 0x00FF→0x0000.

Boundary rules:
- START in any non-IDLE state (repeated START): return to RX_CTRL, Reg_addr kept. This supports the dummy-write + random-read sequence.
- STOP in any state: go to IDLE and release Sda. Done pulses only if the control word matched. A partial byte is discarded with no Reg_wr.
- Reset mid-transfer: Sda released immediately (asynchronous).
- Simultaneous START and STOP detection is impossible. STOP has priority.

Optional Feature:
Macro I2C_SLV_GLITCH_FILTER_EN.
- Defined: after synchronization, Scl and Sda each pass a majority/stability filter. The filtered value changes only after 4 consecutive equal samples, suppressing spikes under 4 Clk (80 ns at 50 MHz). Adds 4 Clk detection latency.
- Undefined: synchronizer output is used directly.

Decomposition:
- Shared package i2c_pkg: state encodings (one-hot, 10 states), DEV_TYPE default 4'b1010, the R/W bit position, and ACK/NACK constants. The master controller shares the same package.
- One natural sub-module: i2c_line_cond.
  - Synchronizer, optional glitch filter, edge/START/STOP detect.
  - Instantiated once; outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Device_addr=3'b001, master writes 0xA5,0x5A to word 0x0010 (WADDR_BYTES=2) → ACK on all 5 bytes; Reg_wr at addr 0x0010/data 0xA5, then 0x0011/0x5A; Done=1 once at STOP.
- Control word addresses 3'b010 while strap=3'b001 → Sda never driven (master sees NACK), no Reg_wr/Reg_rd, Busy stays 1 until STOP.
- Random read with dummy write of 0x0020, repeated START, 3-byte read, memory[n]=n → Reg_rd at 0x0020..0x0022; bus returns 0x20,0x21,0x22; master NACK on the third byte ends TX, Sda released.
- Sequential write starting at 0xFFFF, 2 bytes → Reg_wr at 0xFFFF then 0x0000.
- Rst_n asserted in the middle of bit 4 of a data byte → Sda z within 0 Clk, all outputs at reset values, next START handled normally.
- With I2C_SLV_GLITCH_FILTER_EN, inject 2-Clk low pulse on Sda while Scl high → no START detected; without macro → spurious START, state RX_CTRL.
